// File: rtl/keystream_serialiser.sv
// keystream_serialiser: takes one WORDS x WORD_W keystream block through a
// valid/ready handshake and streams it out as OUT_W-bit beats.
// Word 0 goes first. BIG_ENDIAN chooses which end of each word leaves first.
// in_len truncates the block; 0 or any value above NBEATS means the whole block.
// Optional build macro: SERIALISER_BLK_CNT_EN adds a 32-bit blk_cnt output
// that counts completed (not flushed) blocks.
//
// state  | meaning
// IDLE   | no block held; in_ready high, out_valid low, out_data zero
// STREAM | presenting beat cnt of the held block; out_valid high
module keystream_serialiser #(
  parameter int WORDS      = 16,
  parameter int WORD_W     = 32,
  parameter int OUT_W      = 8,
  parameter int BIG_ENDIAN = 0,
  localparam int BPW       = WORD_W / OUT_W,
  localparam int NBEATS    = WORDS * BPW,
  localparam int LEN_W     = $clog2(NBEATS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORDS*WORD_W-1:0] in_block,
  input  logic [LEN_W-1:0]        in_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
`ifdef SERIALISER_BLK_CNT_EN
  ,
  output logic [31:0]             blk_cnt
`endif
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                  state, state_nxt;
  logic [WORDS*WORD_W-1:0] data_reg;
  logic [LEN_W-1:0]        cnt;
  logic [LEN_W-1:0]        len_reg;
  logic [LEN_W-1:0]        len_m1;
  logic [LEN_W-1:0]        len_clamped;
  logic [WORD_W-1:0]       word_sel;
  logic                    beat_acc;
  logic                    last_acc;
  logic                    load;
  int                      w_idx;
  int                      j_idx;
  int                      s_idx;

  // Zero or oversized lengths mean a full block.
  always_comb begin
    len_clamped = in_len;
    if (in_len == '0 || in_len > LEN_W'(NBEATS)) len_clamped = LEN_W'(NBEATS);
  end

  // Beat selection: word cnt/BPW, slice within the word set by BIG_ENDIAN.
  // Constant-index mux loops keep every select statically in range.
  always_comb begin
    w_idx    = int'(cnt) / BPW;
    j_idx    = int'(cnt) % BPW;
    s_idx    = (BIG_ENDIAN != 0) ? (BPW - 1 - j_idx) : j_idx;
    word_sel = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w_idx == i) word_sel = data_reg[i*WORD_W +: WORD_W];
    end
    out_data = '0;
    if (state == STREAM) begin
      for (int s = 0; s < BPW; s++) begin
        if (s_idx == s) out_data = word_sel[s*OUT_W +: OUT_W];
      end
    end
  end

  // Handshake decode; in_ready is low during reset and whenever flush is up.
  always_comb begin
    len_m1    = len_reg - LEN_W'(1);
    out_valid = (state == STREAM);
    out_last  = (state == STREAM) && (cnt == len_m1);
    beat_acc  = out_valid && out_ready;
    last_acc  = beat_acc && out_last;
    in_ready  = !rst && !flush && ((state == IDLE) || last_acc);
    load      = in_valid && in_ready;
  end

  // Next state: flush wins over a last-beat accept and over a pending load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (load) state_nxt = STREAM;
      STREAM: begin
        if (flush)         state_nxt = IDLE;
        else if (last_acc) state_nxt = load ? STREAM : IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Block capture and beat counter; cnt returns to 0 whenever the block ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      len_reg  <= '0;
      cnt      <= '0;
    end else if (load) begin
      data_reg <= in_block;
      len_reg  <= len_clamped;
      cnt      <= '0;
    end else if (state == STREAM && (flush || last_acc)) begin
      cnt      <= '0;
    end else if (beat_acc) begin
      cnt      <= cnt + LEN_W'(1);
    end
  end

`ifdef SERIALISER_BLK_CNT_EN
  // Completed-block counter; a flushed block never reaches its counted last beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    blk_cnt <= '0;
    else if (last_acc && !flush) blk_cnt <= blk_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_keystream_serialiser.sv
// Bench for keystream_serialiser: an LE and a BE instance share all inputs.
// A negedge monitor keeps a queue of expected beats built from each accepted
// block and checks every cycle; directed tables and sequences cover the
// test-plan corners, then a randomized run exercises everything together.
module tb_keystream_serialiser;
  localparam int WORDS  = 16;
  localparam int WORD_W = 32;
  localparam int NBEATS = 64;
  localparam int BW     = WORDS * WORD_W;

  typedef struct {
    logic [7:0] d_le;
    logic [7:0] d_be;
    bit         last;
  } beat_t;

  typedef struct {
    logic [6:0] len;
    int         bp;
    int         exp_n;
  } vec_t;

  logic          clk = 0;
  logic          rst = 1;
  logic [BW-1:0] in_block = '0;
  logic [6:0]    in_len = '0;
  logic          in_valid = 0;
  logic          flush = 0;
  logic          out_ready = 1;
  logic          in_ready_le, in_ready_be;
  logic [7:0]    out_data_le, out_data_be;
  logic          out_valid_le, out_valid_be;
  logic          out_last_le, out_last_be;
`ifdef SERIALISER_BLK_CNT_EN
  logic [31:0]   blk_cnt_le, blk_cnt_be;
`endif

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  logic [31:0] exp_blk = 0;
  logic [7:0]  s_dle, s_dbe;
  bit          s_valid;

  keystream_serialiser #(.BIG_ENDIAN(0)) u_le (
    .clk(clk), .rst(rst), .in_block(in_block), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_le), .flush(flush),
    .out_data(out_data_le), .out_valid(out_valid_le), .out_ready(out_ready),
    .out_last(out_last_le)
`ifdef SERIALISER_BLK_CNT_EN
    , .blk_cnt(blk_cnt_le)
`endif
  );

  keystream_serialiser #(.BIG_ENDIAN(1)) u_be (
    .clk(clk), .rst(rst), .in_block(in_block), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_be), .flush(flush),
    .out_data(out_data_be), .out_valid(out_valid_be), .out_ready(out_ready),
    .out_last(out_last_be)
`ifdef SERIALISER_BLK_CNT_EN
    , .blk_cnt(blk_cnt_be)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Expand a block into its beat sequence from the byte-order rules.
  function automatic void push_block(input logic [BW-1:0] blk, input logic [6:0] len);
    int n;
    logic [31:0] word;
    beat_t b;
    n = (len == 0 || len > NBEATS) ? NBEATS : int'(len);
    for (int k = 0; k < n; k++) begin
      word   = blk[(k/4)*32 +: 32];
      b.d_le = 8'(word >> (8 * (k % 4)));
      b.d_be = 8'(word >> (8 * (3 - k % 4)));
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [BW-1:0] pattern_block();
    logic [BW-1:0] b;
    for (int i = 0; i < WORDS; i++)
      b[i*32 +: 32] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
    return b;
  endfunction

  function automatic logic [BW-1:0] random_block();
    logic [BW-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Reference monitor: expected outputs follow from the queue of pending beats.
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      chk("rst_valid_le", 32'(out_valid_le), 0);
      chk("rst_valid_be", 32'(out_valid_be), 0);
      chk("rst_data_le", 32'(out_data_le), 0);
      chk("rst_last_le", 32'(out_last_le), 0);
      chk("rst_in_ready", 32'(in_ready_le), 0);
      exp_q.delete();
      exp_blk = 0;
    end else begin
      exp_rdy = !flush && (exp_q.size() == 0 || (exp_q[0].last && out_ready));
      if (exp_q.size() == 0) begin
        chk("idle_valid_le", 32'(out_valid_le), 0);
        chk("idle_valid_be", 32'(out_valid_be), 0);
        chk("idle_data_le", 32'(out_data_le), 0);
        chk("idle_data_be", 32'(out_data_be), 0);
        chk("idle_last_le", 32'(out_last_le), 0);
      end else begin
        chk("valid_le", 32'(out_valid_le), 1);
        chk("valid_be", 32'(out_valid_be), 1);
        chk("data_le", 32'(out_data_le), 32'(exp_q[0].d_le));
        chk("data_be", 32'(out_data_be), 32'(exp_q[0].d_be));
        chk("last_le", 32'(out_last_le), 32'(exp_q[0].last));
        chk("last_be", 32'(out_last_be), 32'(exp_q[0].last));
      end
      chk("in_ready_le", 32'(in_ready_le), 32'(exp_rdy));
      chk("in_ready_be", 32'(in_ready_be), 32'(exp_rdy));
`ifdef SERIALISER_BLK_CNT_EN
      chk("blk_cnt_le", blk_cnt_le, exp_blk);
      chk("blk_cnt_be", blk_cnt_be, exp_blk);
`endif
      if (exp_q.size() != 0) begin
        if (flush) exp_q.delete();
        else if (out_ready) begin
          if (exp_q[0].last) exp_blk++;
          void'(exp_q.pop_front());
        end
      end
      if (in_valid && exp_rdy) push_block(in_block, in_len);
    end
  end

  // One cycle: sample at negedge, then step past the next rising edge.
  task automatic tick(output bit took, output bit bt, output bit lb);
    @(negedge clk);
    took    = in_valid && in_ready_le;
    bt      = out_valid_le && out_ready;
    lb      = bt && out_last_le;
    s_dle   = out_data_le;
    s_dbe   = out_data_be;
    s_valid = out_valid_le;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input string nm);
    bit took, bt, lb;
    int g = 0;
    took = 0;
    while (!took && g < 200) begin tick(took, bt, lb); g++; end
    if (!took) chk({nm, "_load_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string nm);
    bit took, bt, lb;
    int g = 0;
    s_valid = 1;
    while (s_valid && g < 400) begin tick(took, bt, lb); g++; end
    if (s_valid) chk({nm, "_idle_timeout"}, 0, 1);
  endtask

  task automatic run_block(input logic [BW-1:0] blk, input logic [6:0] len,
                           input int bp, output int nbeats);
    bit took, bt, lb;
    int g = 0;
    int ph = 0;
    in_block = blk; in_len = len; in_valid = 1; out_ready = 1;
    wait_load("run");
    in_valid = 0;
    nbeats = 0; lb = 0;
    while (!lb && g < 1000) begin
      case (bp)
        0:       out_ready = 1;
        1:       out_ready = (ph % 2 == 0);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      ph++;
      tick(took, bt, lb);
      if (bt) nbeats++;
      g++;
    end
    if (!lb) chk("run_last_timeout", 0, 1);
    out_ready = 1;
  endtask

  initial begin
    vec_t vt[8];
    bit took, bt, lb;
    int n, cyc;
    logic [BW-1:0] blk_b;
    logic [31:0] bc0;

    vt[0] = '{len: 7'd0,   bp: 0, exp_n: 64};
    vt[1] = '{len: 7'd1,   bp: 0, exp_n: 1};
    vt[2] = '{len: 7'd5,   bp: 1, exp_n: 5};
    vt[3] = '{len: 7'd63,  bp: 2, exp_n: 63};
    vt[4] = '{len: 7'd64,  bp: 1, exp_n: 64};
    vt[5] = '{len: 7'd65,  bp: 0, exp_n: 64};
    vt[6] = '{len: 7'd127, bp: 2, exp_n: 64};
    vt[7] = '{len: 7'd2,   bp: 1, exp_n: 2};

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready_le), 1);
    @(posedge clk); #1;

    // Full block, both byte orders, unstalled.
    in_block = pattern_block(); in_len = 0; in_valid = 1; out_ready = 1;
    wait_load("full");
    in_valid = 0;
    @(negedge clk);
    chk("first_le", 32'(out_data_le), 32'h00);
    chk("first_be", 32'(out_data_be), 32'h03);
    @(posedge clk); #1;
    cyc = 1; lb = 0;
    while (!lb && cyc < 200) begin tick(took, bt, lb); if (s_valid) cyc++; end
    chk("full_valid_cycles", 32'(cyc), 64);
    chk("full_last_le", 32'(s_dle), 32'h3F);
    chk("full_last_be", 32'(s_dbe), 32'h3C);
    wait_idle("full");

    // Table: lengths and backpressure patterns.
    foreach (vt[i]) begin
      run_block(random_block(), vt[i].len, vt[i].bp, n);
      chk($sformatf("len_tbl_%0d", i), 32'(n), 32'(vt[i].exp_n));
      wait_idle("tbl");
    end

    // Truncated block with toggling ready: final beat value.
    run_block(pattern_block(), 7'd5, 1, n);
    chk("trunc_last_le", 32'(s_dle), 32'h04);

    // Back-to-back: second block loads on the first block's last beat.
`ifdef SERIALISER_BLK_CNT_EN
    bc0 = blk_cnt_le;
`else
    bc0 = 0;
`endif
    blk_b = random_block();
    blk_b[31:0] = 32'hAABBCCDD;
    in_block = pattern_block(); in_len = 0; in_valid = 1; out_ready = 1;
    wait_load("b2b_a");
    in_block = blk_b;
    took = 0; cyc = 0;
    while (!took && cyc < 200) begin tick(took, bt, lb); cyc++; end
    chk("b2b_load_on_last", 32'(lb), 1);
    chk("b2b_prev_beat", 32'(s_dle), 32'h3F);
    in_valid = 0;
    @(negedge clk);
    chk("b2b_no_bubble", 32'(out_valid_le), 1);
    chk("b2b_next_le", 32'(out_data_le), 32'hDD);
    chk("b2b_next_be", 32'(out_data_be), 32'hAA);
    @(posedge clk); #1;
    wait_idle("b2b");
`ifdef SERIALISER_BLK_CNT_EN
    chk("b2b_blk_cnt", blk_cnt_le - bc0, 2);
`endif

    // Flush at beat 10 with a new block on offer.
    in_block = pattern_block(); in_len = 0; in_valid = 1;
    wait_load("flush");
    in_valid = 0;
    repeat (10) tick(took, bt, lb);
    chk("flush_at_beat10", 32'(out_data_le), 32'h0A);
    in_block = blk_b; in_valid = 1; flush = 1;
    tick(took, bt, lb);
    chk("flush_no_load", 32'(took), 0);
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_valid_low", 32'(out_valid_le), 0);
    @(posedge clk); #1;

    // Reset mid-block at beat 20.
    in_block = pattern_block(); in_len = 0; in_valid = 1;
    wait_load("rstmid");
    in_valid = 0;
    repeat (20) tick(took, bt, lb);
    rst = 1;
    #1;
    chk("rstmid_valid", 32'(out_valid_le), 0);
    chk("rstmid_last", 32'(out_last_le), 0);
    chk("rstmid_data", 32'(out_data_le), 0);
    chk("rstmid_ready", 32'(in_ready_le), 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rstmid_ready_after", 32'(in_ready_le), 1);
    chk("rstmid_no_beats", 32'(out_valid_le), 0);
    @(posedge clk); #1;
    run_block(pattern_block(), 7'd3, 0, n);
    chk("rstmid_restart_len", 32'(n), 3);
    chk("rstmid_restart_last", 32'(s_dle), 32'h02);

    // Randomized traffic checked by the monitor.
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_block  = random_block();
      in_len    = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                              : 7'($urandom_range(1, 8));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      tick(took, bt, lb);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    wait_idle("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
